// File: rtl/daqadcreader.sv
// ADC readout engine: on a synchronized BUSY fall, serially reads NUM_CH words
// from the ADC and streams them, channel-tagged, on a valid/ready interface.
module daqadcreader #(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              en_i,
    input  logic              busy_i,
    output logic              cs_n_o,
    output logic              sclk_o,
    input  logic              sdata_i,
    output logic [DATA_W-1:0] sample_o,
    output logic [2:0]        chan_o,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              frame_done_o,
    output logic              overrun_o
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned DIV_W = $clog2(SCLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [2:0]       CH_LAST  = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOW, S_HIGH, S_OUT, S_DONE
    } state_t;

    state_t            r_state;
    logic              r_s1, r_s2, r_p;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit;
    logic [2:0]        r_ch;
    logic [DATA_W-1:0] r_shift;
    logic              w_fall;

    // Reset-to-0 flops guarantee a static BUSY level never looks like an edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_p  <= 1'b0;
        end else begin
            r_s1 <= busy_i;
            r_s2 <= r_s1;
            r_p  <= r_s2;
        end
    end

    assign w_fall = r_p & ~r_s2;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state        <= S_IDLE;
            r_div          <= '0;
            r_bit          <= '0;
            r_ch           <= '0;
            r_shift        <= '0;
            cs_n_o         <= 1'b1;
            sclk_o         <= 1'b1;
            sample_o       <= '0;
            chan_o         <= '0;
            sample_valid_o <= 1'b0;
            frame_done_o   <= 1'b0;
            overrun_o      <= 1'b0;
        end else if (!en_i) begin
            r_state        <= S_IDLE;
            r_div          <= '0;
            r_bit          <= '0;
            r_ch           <= '0;
            cs_n_o         <= 1'b1;
            sclk_o         <= 1'b1;
            sample_valid_o <= 1'b0;
            frame_done_o   <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            if (w_fall && r_state != S_IDLE)
                overrun_o <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_SETUP;
                        cs_n_o  <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_ch    <= '0;
                    end
                end
                S_SETUP: begin
                    if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        r_state <= S_LOW;
                        sclk_o  <= 1'b0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        r_state <= S_HIGH;
                        sclk_o  <= 1'b1;
                        r_shift <= (r_shift << 1) | DATA_W'(sdata_i);
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (r_bit != BIT_LAST) begin
                            r_bit   <= r_bit + 1'b1;
                            r_state <= S_LOW;
                            sclk_o  <= 1'b0;
                        end else begin
                            sample_o       <= r_shift;
                            chan_o         <= r_ch;
                            sample_valid_o <= 1'b1;
                            r_state        <= S_OUT;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_OUT: begin
                    // SCLK parks high while the word waits for acceptance.
                    if (sample_ready_i) begin
                        sample_valid_o <= 1'b0;
                        if (r_ch != CH_LAST) begin
                            r_ch    <= r_ch + 1'b1;
                            r_bit   <= '0;
                            r_state <= S_LOW;
                            sclk_o  <= 1'b0;
                        end else begin
                            r_state      <= S_DONE;
                            cs_n_o       <= 1'b1;
                            frame_done_o <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_daqadcreader.sv
// Directed-sequence bench for daqadcreader: default instance plus a small
// NUM_CH=2/DATA_W=12/SCLK_DIV=2 instance, each driven by a behavioural ADC.
module tb_daqadcreader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en_a = 1'b1, busy_a = 1'b0, sdata_a = 1'b0, rdy_a = 1'b1;
    logic        cs_a, sclk_a, val_a, done_a, ov_a;
    logic [15:0] smp_a;
    logic [2:0]  ch_a;

    logic        en_b = 1'b1, busy_b = 1'b0, sdata_b = 1'b0, rdy_b = 1'b1;
    logic        cs_b, sclk_b, val_b, done_b, ov_b;
    logic [11:0] smp_b;
    logic [2:0]  ch_b;

    daqadcreader u_a (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en_a), .busy_i(busy_a),
        .cs_n_o(cs_a), .sclk_o(sclk_a), .sdata_i(sdata_a),
        .sample_o(smp_a), .chan_o(ch_a), .sample_valid_o(val_a),
        .sample_ready_i(rdy_a), .frame_done_o(done_a), .overrun_o(ov_a)
    );

    daqadcreader #(.NUM_CH(2), .DATA_W(12), .SCLK_DIV(2)) u_b (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en_b), .busy_i(busy_b),
        .cs_n_o(cs_b), .sclk_o(sclk_b), .sdata_i(sdata_b),
        .sample_o(smp_b), .chan_o(ch_b), .sample_valid_o(val_b),
        .sample_ready_i(rdy_b), .frame_done_o(done_b), .overrun_o(ov_b)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] wa [8];
    logic [11:0] wb [2];

    // ADC model: counts SCLK falls since CS fell and presents word bits MSB first.
    int fa = 0;
    logic [2:0] ca;
    logic [3:0] ba;
    always @(negedge sclk_a or negedge cs_a) begin
        if (sclk_a) begin
            fa = 0;
        end else if (!cs_a && fa < 128) begin
            ca = 3'(fa / 16);
            ba = 4'(15 - fa % 16);
            sdata_a = wa[ca][ba];
            fa++;
        end
    end

    int fb = 0;
    logic       cb;
    logic [3:0] bb;
    always @(negedge sclk_b or negedge cs_b) begin
        if (sclk_b) begin
            fb = 0;
        end else if (!cs_b && fb < 24) begin
            cb = 1'(fb / 12);
            bb = 4'(11 - fb % 12);
            sdata_b = wb[cb][bb];
            fb++;
        end
    end

    logic [18:0] got_a[$];
    int frames_a = 0, dones_a = 0, dbad_a = 0, low_a = 0, len_a = 0;
    bit prev_a = 1'b0;
    always @(negedge clk) begin
        #1;
        if (val_a && rdy_a) got_a.push_back({ch_a, smp_a});
        if (done_a) begin
            dones_a++;
            if (!(cs_a && prev_a)) dbad_a++;
        end
        if (!cs_a) low_a++;
        else if (prev_a) begin
            len_a = low_a;
            low_a = 0;
            frames_a++;
        end
        prev_a = !cs_a;
    end

    logic [14:0] got_b[$];
    int frames_b = 0, dones_b = 0, low_b = 0, len_b = 0;
    bit prev_b = 1'b0;
    always @(negedge clk) begin
        #1;
        if (val_b && rdy_b) got_b.push_back({ch_b, smp_b});
        if (done_b) dones_b++;
        if (!cs_b) low_b++;
        else if (prev_b) begin
            len_b = low_b;
            low_b = 0;
            frames_b++;
        end
        prev_b = !cs_b;
    end

    int base_a = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic busy_fall_a();
        busy_a = 1'b1;
        repeat (3) @(negedge clk);
        busy_a = 1'b0;
    endtask

    task automatic wait_frames_a(input int target, input string tag);
        for (int k = 0; k < 3000 && frames_a < target; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_frames"}, 32'(frames_a), 32'(target));
    endtask

    task automatic wait_word_a(input int ch, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            seen = val_a && (32'(ch_a) == 32'(ch));
        end
        check({tag, "_seen"}, 32'(seen), 32'(1));
    endtask

    task automatic check_frame_a(input string tag, input int exp_len);
        int n;
        n = got_a.size() - base_a;
        check({tag, "_nwords"}, 32'(n), 32'(8));
        for (int i = 0; i < 8 && i < n; i++) begin
            check({tag, "_chan"}, 32'(got_a[base_a + i][18:16]), 32'(i));
            check({tag, "_data"}, 32'(got_a[base_a + i][15:0]), 32'(wa[3'(i)]));
        end
        check({tag, "_len"}, 32'(len_a), 32'(exp_len));
        base_a = got_a.size();
    endtask

    task automatic rand_words_a();
        for (int i = 0; i < 8; i++) wa[3'(i)] = 16'($urandom);
    endtask

    initial begin
        logic [15:0] hold_s;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            busy_a = 1'($urandom);
            en_a   = 1'($urandom);
            rdy_a  = 1'($urandom);
            check("rst_cs",    32'(cs_a),   32'(1));
            check("rst_sclk",  32'(sclk_a), 32'(1));
            check("rst_valid", 32'(val_a),  32'(0));
            check("rst_data",  32'(smp_a),  32'(0));
            check("rst_chan",  32'(ch_a),   32'(0));
            check("rst_done",  32'(done_a), 32'(0));
            check("rst_ovr",   32'(ov_a),   32'(0));
            check("rst_cs_b",  32'(cs_b),   32'(1));
        end
        busy_a = 1'b0;
        en_a   = 1'b1;
        rdy_a  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_cs", 32'(cs_a), 32'(1));
        check("idle_frames", 32'(frames_a), 32'(0));

        // single frame with fixed pattern and latency check
        for (int i = 0; i < 8; i++) wa[3'(i)] = 16'(16'hA5C3 + i);
        busy_fall_a();
        repeat (2) @(negedge clk);
        check("lat_cs_pre", 32'(cs_a), 32'(1));
        @(negedge clk);
        check("lat_cs", 32'(cs_a), 32'(0));
        wait_frames_a(1, "f1");
        check_frame_a("f1", 1036);
        check("f1_dones", 32'(dones_a), 32'(1));
        check("f1_done_pos", 32'(dbad_a), 32'(0));

        // backpressure on channel 3 for five cycles
        rand_words_a();
        busy_fall_a();
        wait_word_a(2, "bp2");
        @(negedge clk);
        rdy_a = 1'b0;
        wait_word_a(3, "bp3");
        hold_s = smp_a;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(val_a),  32'(1));
            check("bp_data",  32'(smp_a),  32'(hold_s));
            check("bp_chan",  32'(ch_a),   32'(3));
            check("bp_sclk",  32'(sclk_a), 32'(1));
        end
        rdy_a = 1'b1;
        wait_frames_a(2, "bp");
        check_frame_a("bp", 1041);

        // overrun: second BUSY fall during channel 2
        rand_words_a();
        busy_fall_a();
        wait_word_a(1, "ov1");
        repeat (20) @(negedge clk);
        busy_fall_a();
        repeat (2) @(negedge clk);
        check("ov_early", 32'(ov_a), 32'(0));
        @(negedge clk);
        check("ov_set", 32'(ov_a), 32'(1));
        wait_frames_a(3, "ov");
        check_frame_a("ov", 1036);
        repeat (100) @(negedge clk);
        check("ov_no_frame", 32'(frames_a), 32'(3));
        check("ov_cs_idle",  32'(cs_a), 32'(1));
        check("ov_sticky",   32'(ov_a), 32'(1));
        en_a = 1'b0;
        @(negedge clk);
        en_a = 1'b1;
        check("ov_clear", 32'(ov_a), 32'(0));
        check("ov_dones", 32'(dones_a), 32'(3));

        // abort mid-bit of channel 5
        rand_words_a();
        busy_fall_a();
        wait_word_a(4, "ab4");
        repeat (10) @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        en_a = 1'b1;
        check("ab_cs",    32'(cs_a),   32'(1));
        check("ab_sclk",  32'(sclk_a), 32'(1));
        check("ab_valid", 32'(val_a),  32'(0));
        check("ab_done",  32'(done_a), 32'(0));
        repeat (200) @(negedge clk);
        check("ab_words", 32'(got_a.size() - base_a), 32'(5));
        check("ab_nodone", 32'(dones_a), 32'(3));
        base_a = got_a.size();
        rand_words_a();
        busy_fall_a();
        wait_frames_a(5, "ab2");
        check_frame_a("ab2", 1036);
        check("ab2_dones", 32'(dones_a), 32'(4));
        check("a_done_pos", 32'(dbad_a), 32'(0));

        // parameter variant
        for (int i = 0; i < 2; i++) wb[1'(i)] = 12'($urandom);
        busy_b = 1'b1;
        repeat (3) @(negedge clk);
        busy_b = 1'b0;
        for (int k = 0; k < 1000 && frames_b < 1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("v_frames", 32'(frames_b), 32'(1));
        check("v_nwords", 32'(got_b.size()), 32'(2));
        for (int i = 0; i < 2 && i < got_b.size(); i++) begin
            check("v_chan", 32'(got_b[i][14:12]), 32'(i));
            check("v_data", 32'(got_b[i][11:0]),  32'(wb[1'(i)]));
        end
        check("v_len",   32'(len_b),   32'(100));
        check("v_dones", 32'(dones_b), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/daqadcreader.md
# daqadcreader

Readout half of the Platypus DAQ conversion handshake. `daqtriggerctrl` drives the ADC conversion-start clock and consumes BUSY. This block watches the same BUSY line. When BUSY falls, meaning the ADC conversion is complete, it runs a serial read of every channel result from the ADC. It then presents each word, tagged with its channel number, on a valid/ready stream toward the capture buffer. It runs in the 192 MHz DCM domain.

## Interface
Parameters:
- `NUM_CH`, default 8: channels read per frame. Legal range is 1–8.
- `DATA_W`, default 16: bits per channel word.
- `SCLK_DIV`, default 4: length of each SCLK phase in `clk_i` cycles. Must be at least 2. The default gives SCLK = 24 MHz.

Ports:
- `clk_i`, input, 1: system clock (`clk_fast`, 192 MHz).
- `reset_n_i`, input, 1: asynchronous, active-low reset.
- `en_i`, input, 1: enable. When low, the block returns to IDLE synchronously.
- `busy_i`, input, 1: ADC BUSY. Asynchronous to `clk_i`; synchronized internally.
- `cs_n_o`, output, 1: ADC chip select, active-low.
- `sclk_o`, output, 1: ADC serial clock. Idles high.
- `sdata_i`, input, 1: ADC serial data, MSB first. The ADC changes it after SCLK falls.
- `sample_o`, output, DATA_W: channel word.
- `chan_o`, output, 3: channel index of `sample_o`.
- `sample_valid_o`, output, 1: `sample_o` and `chan_o` are valid.
- `sample_ready_i`, input, 1: downstream accepts the word.
- `frame_done_o`, output, 1: one-cycle pulse after the last channel word is accepted.
- `overrun_o`, output, 1: sticky. Set when a new conversion ends before the current frame has finished.

## Operation
- **BUSY synchronizer:** two flops (`s1`, `s2`) plus a previous-value flop `p`, all reset to 0. A falling edge is defined as `p & ~s2`. Because the flops reset to 0, busy held low or high out of reset never produces an edge.
- **States:** IDLE, SETUP, LOW, HIGH, OUT, DONE.
- **IDLE:**
  - `cs_n_o`=1, `sclk_o`=1, `sample_valid_o`=0.
  - A falling edge while `en_i`=1 moves to SETUP, with `cs_n_o` driven to 0.
- **SETUP:** lasts SCLK_DIV cycles, then moves to LOW. Bit counter is cleared to 0; channel counter is cleared to 0.
- **LOW:** `sclk_o`=0 for SCLK_DIV cycles, then moves to HIGH.
- **HIGH:**
  - On the clock edge that enters HIGH, `sclk_o` goes to 1 and `sdata_i` is shifted into the LSB of the shift register. Earlier bits move toward the MSB.
  - HIGH lasts SCLK_DIV cycles. After that:
    - if the bit counter is below DATA_W-1: increment it and move to LOW;
    - otherwise: load `sample_o` from the shift register, load `chan_o` from the channel counter, set `sample_valid_o`=1, and move to OUT.
- **OUT:**
  - `sclk_o` is held at 1 and `sample_o`/`chan_o` are held stable while `sample_valid_o`=1 and `sample_ready_i`=0.
  - On the cycle `sample_valid_o`=1 and `sample_ready_i`=1, the word is accepted and `sample_valid_o` drops on the next edge. Then:
    - if the channel counter is below NUM_CH-1: increment it, clear the bit counter, and move to LOW;
    - otherwise: move to DONE.
- **DONE:** lasts one cycle. `cs_n_o`=1 and `frame_done_o`=1 in that cycle, then the block moves to IDLE.
- **Overrun:**
  - A falling edge detected in any state other than IDLE sets `overrun_o` and is otherwise ignored. The frame in progress continues unaffected.
  - `overrun_o` is cleared only by reset or by `en_i`=0.
- **`en_i`=0 in any state:** on the next edge the block goes to IDLE, with `cs_n_o`=1, `sclk_o`=1, `sample_valid_o`=0, `frame_done_o`=0 and `overrun_o`=0. A partially received word is discarded.
- **Reset values (asynchronous):** `cs_n_o`=1, `sclk_o`=1, `sample_o`=0, `chan_o`=0, `sample_valid_o`=0, `frame_done_o`=0, `overrun_o`=0, state IDLE, all counters 0.
- **Reset mid-frame:** all outputs go to their reset values immediately; no `frame_done_o` is produced.

## Timing
- **BUSY edge to chip select:** `busy_i` falls before clock edge N. Edge N samples it into `s1`, edge N+1 propagates it to `s2`, and `cs_n_o` is 0 after edge N+2.
- **First SCLK fall:** SCLK_DIV cycles after `cs_n_o` falls.
- **Per bit:** 2·SCLK_DIV cycles. `sdata_i` must be stable at the clock edge where `sclk_o` rises.
- **Per channel, with `sample_ready_i`=1:** 2·DATA_W·SCLK_DIV + 1 cycles, where the extra cycle is OUT.
- **Each backpressure cycle** adds exactly one cycle to the channel time.
- **Frame length with defaults and `sample_ready_i`=1:** `cs_n_o` is low for 4 + 8·129 = 1036 cycles.
- **Frame end:** `frame_done_o` occupies the first cycle with `cs_n_o`=1.
- **Back-to-back frames:** the earliest next frame starts, with `cs_n_o` low again, 3 cycles after the next BUSY fall that arrives while the block is in IDLE.

## Test plan
- **Reset state:** hold `reset_n_i`=0 with random inputs. All outputs stay at their reset values: `cs_n_o`=1, `sclk_o`=1, `sample_valid_o`=0.
- **Single frame with defaults:**
  - Stimulus: ADC model returns 0xA5C3 + ch for channels 0..7; `sample_ready_i`=1.
  - Required response:
    - eight words 0xA5C3..0xA5CA with `chan_o` 0..7;
    - `cs_n_o` low for 1036 cycles, starting 3 cycles after the BUSY fall;
    - `frame_done_o` pulses once.
- **Backpressure:**
  - Stimulus: same frame, with `sample_ready_i` held low for 5 cycles on channel 3.
  - Required response:
    - `sample_o`/`chan_o` stable and `sclk_o`=1 throughout the stall;
    - data still correct;
    - `cs_n_o` low for 1041 cycles.
- **Overrun:**
  - Stimulus: a second BUSY fall arrives during channel 2.
  - Required response: `overrun_o`=1 from 3 cycles after that fall; the frame completes with all 8 words; no second frame starts; `overrun_o` stays 1 until `en_i`=0.
- **Abort:** drop `en_i` for one cycle mid-bit of channel 5.
  - Required response: next edge gives `cs_n_o`=1 and `sclk_o`=1, with no `frame_done_o` and no further words.
  - Then a new BUSY fall produces a clean frame starting at channel 0.
- **Parameter variant:** NUM_CH=2, DATA_W=12, SCLK_DIV=2. Required response: two 12-bit words, and `cs_n_o` low for 2 + 2·49 = 100 cycles.
